// File: rtl/irrigation_pkg.sv
// Shared definitions for the irrigation scheduler: controller state encoding
// and default moisture thresholds / reading width.
package irrigation_pkg;

  localparam int DEF_MOIST_W    = 4;
  localparam int DEF_DRY_THRESH = 5;
  localparam int DEF_WET_THRESH = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPEN,
    ST_WATER,
    ST_CLOSE,
    ST_COOL
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req   - per-zone request vector
//   ptr   - index with highest priority this cycle
//   grant - first requesting index at or after ptr (wrapping)
//   valid - at least one request present
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          valid
);

  logic [IW-1:0] idx;

  // Walk from the farthest offset back to ptr so the nearest requester is
  // the last one written and therefore wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irrigation_scheduler.sv
// Shares one pump between NUM_ZONES valves. Grants one dry zone at a time
// (round-robin), then sequences valve open, settle, pump run, pump off,
// valve close and cooldown. Zones that hit the run-time limit are locked
// out until clear_fault.
// Ports:
//   clk, reset     - clock, async active-low reset
//   start          - watering permitted (level)
//   moisture       - packed per-zone readings, zone i at [i*MOIST_W +: MOIST_W]
//   zone_enable    - per-zone enable mask
//   clear_fault    - pulse, clears all lockout bits
//   pump, valve    - actuator drives (valve one-hot or zero)
//   active_zone    - index of the granted zone
//   busy           - controller not idle
//   timeout_pulse  - one cycle when a grant hits MAX_ON
//   lockout        - sticky per-zone timeout faults
//
// state | meaning
// IDLE  | waiting for start and a dry, enabled, unlocked zone
// OPEN  | valve open, letting line pressure settle
// WATER | pump running, checking abort / timeout / wet
// CLOSE | pump off, valve still open
// COOL  | everything off before the next grant
module irrigation_scheduler
  import irrigation_pkg::*;
#(
  parameter int NUM_ZONES    = 4,
  parameter int MOIST_W      = DEF_MOIST_W,
  parameter int DRY_THRESH   = DEF_DRY_THRESH,
  parameter int WET_THRESH   = DEF_WET_THRESH,
  parameter int VALVE_SETTLE = 2,
  parameter int MIN_ON       = 8,
  parameter int MAX_ON       = 32,
  parameter int COOLDOWN     = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_ZONES*MOIST_W-1:0]   moisture,
  input  logic [NUM_ZONES-1:0]           zone_enable,
  input  logic                           clear_fault,
  output logic                           pump,
  output logic [NUM_ZONES-1:0]           valve,
  output logic [$clog2(NUM_ZONES)-1:0]   active_zone,
  output logic                           busy,
  output logic                           timeout_pulse,
  output logic [NUM_ZONES-1:0]           lockout
);

  localparam int ZW = $clog2(NUM_ZONES);
  localparam int CW = $clog2(MAX_ON + 1);

  localparam logic [CW-1:0]      SETTLE_TC = CW'(VALVE_SETTLE - 1);
  localparam logic [CW-1:0]      MIN_TC    = CW'(MIN_ON - 1);
  localparam logic [CW-1:0]      MAX_TC    = CW'(MAX_ON - 1);
  localparam logic [CW-1:0]      COOL_TC   = CW'(COOLDOWN - 1);
  localparam logic [MOIST_W-1:0] DRY_LVL   = MOIST_W'(DRY_THRESH);
  localparam logic [MOIST_W-1:0] WET_LVL   = MOIST_W'(WET_THRESH);

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt, cnt_inc;
  logic [ZW-1:0]          ptr, ptr_nxt, zone_nxt;
  logic [ZW-1:0]          arb_grant;
  logic                   arb_valid;
  logic [NUM_ZONES-1:0]   req, lockout_nxt, valve_nxt;
  logic [MOIST_W-1:0]     moist [NUM_ZONES];
  logic                   abort, tmo;

  always_comb begin
    for (int i = 0; i < NUM_ZONES; i++) begin
      moist[i] = moisture[i*MOIST_W +: MOIST_W];
      req[i]   = zone_enable[i] & ~lockout[i] & (moist[i] < DRY_LVL);
    end
  end

  rr_arbiter #(
    .N  (NUM_ZONES),
    .IW (ZW)
  ) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    zone_nxt  = active_zone;
    ptr_nxt   = ptr;
    tmo       = 1'b0;
    abort     = ~start | ~zone_enable[active_zone];
    cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;

    case (state)
      ST_IDLE: begin
        if (start && arb_valid) begin
          state_nxt = ST_OPEN;
          cnt_nxt   = '0;
          zone_nxt  = arb_grant;
          ptr_nxt   = (arb_grant == ZW'(NUM_ZONES - 1)) ? '0 : arb_grant + 1'b1;
        end
      end
      ST_OPEN: begin
        if (abort) begin
          state_nxt = ST_CLOSE;
        end else if (cnt == SETTLE_TC) begin
          state_nxt = ST_WATER;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_WATER: begin
        // Priority: abort, then timeout, then wet-after-minimum.
        if (abort) begin
          state_nxt = ST_CLOSE;
        end else if (cnt == MAX_TC) begin
          state_nxt = ST_CLOSE;
          tmo       = 1'b1;
        end else if (moist[active_zone] >= WET_LVL && cnt >= MIN_TC) begin
          state_nxt = ST_CLOSE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_CLOSE: begin
        state_nxt = ST_COOL;
        cnt_nxt   = '0;
      end
      ST_COOL: begin
        if (cnt == COOL_TC) state_nxt = ST_IDLE;
        else                cnt_nxt   = cnt_inc;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A timeout on the same edge as clear_fault keeps its bit set.
    lockout_nxt = clear_fault ? '0 : lockout;
    if (tmo) lockout_nxt[active_zone] = 1'b1;

    valve_nxt = '0;
    if (state_nxt == ST_OPEN || state_nxt == ST_WATER || state_nxt == ST_CLOSE)
      valve_nxt[zone_nxt] = 1'b1;
  end

  // Outputs are decoded from the next state so they are registered yet
  // line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      ptr           <= '0;
      active_zone   <= '0;
      lockout       <= '0;
      pump          <= 1'b0;
      valve         <= '0;
      busy          <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      ptr           <= ptr_nxt;
      active_zone   <= zone_nxt;
      lockout       <= lockout_nxt;
      pump          <= (state_nxt == ST_WATER);
      valve         <= valve_nxt;
      busy          <= (state_nxt != ST_IDLE);
      timeout_pulse <= tmo;
    end
  end

endmodule

// File: tb/tb_irrigation_scheduler.sv
module tb_irrigation_scheduler;

  localparam int N      = 4;
  localparam int MW     = 4;
  localparam int DRY    = 5;
  localparam int WET    = 13;
  localparam int SETTLE = 2;
  localparam int MIN_ON = 8;
  localparam int MAX_ON = 32;
  localparam int COOL   = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            clear_fault = 1'b0;
  logic [N*MW-1:0] moisture = '0;
  logic [N-1:0]    zone_enable = '1;
  logic            pump, busy, timeout_pulse;
  logic [N-1:0]    valve, lockout;
  logic [1:0]      active_zone;

  always #5 clk = ~clk;

  irrigation_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .moisture      (moisture),
    .zone_enable   (zone_enable),
    .clear_fault   (clear_fault),
    .pump          (pump),
    .valve         (valve),
    .active_zone   (active_zone),
    .busy          (busy),
    .timeout_pulse (timeout_pulse),
    .lockout       (lockout)
  );

  typedef struct packed {
    logic         pump;
    logic [N-1:0] valve;
    logic [1:0]   az;
    logic         busy;
    logic         tp;
    logic [N-1:0] lk;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // ---------------- reference model ----------------
  logic [N-1:0] m_lk;
  int           m_ptr, m_zone;

  function automatic int m_moist(int z);
    return int'(moisture[z*MW +: MW]);
  endfunction

  function automatic logic [N-1:0] m_req();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++)
      r[i] = zone_enable[i] && !m_lk[i] && (m_moist(i) < DRY);
    return r;
  endfunction

  task automatic m_edge(output bit ok);
    @(posedge clk);
    ok = reset;
  endtask

  // Record outputs expected after this edge; tp also means the zone is locked.
  task automatic m_push(input bit p, input bit vo, input bit b, input bit tp);
    obs_t o;
    if (clear_fault) m_lk = '0;
    if (tp) m_lk[m_zone] = 1'b1;
    o.pump  = p;
    o.valve = '0;
    if (vo) o.valve[m_zone] = 1'b1;
    o.az    = 2'(m_zone);
    o.busy  = b;
    o.tp    = tp;
    o.lk    = m_lk;
    exp_q.push_back(o);
  endtask

  task automatic m_grant(output bit ok);
    logic [N-1:0] r;
    bit ab;
    int n;
    forever begin
      m_edge(ok); if (!ok) return;
      r = m_req();
      if (start && r != '0) begin
        for (int k = 0; k < N; k++)
          if (r[(m_ptr + k) % N]) begin m_zone = (m_ptr + k) % N; break; end
        m_ptr = (m_zone + 1) % N;
        m_push(0, 1, 1, 0);
        break;
      end
      m_push(0, 0, 0, 0);
    end
    ab = 0;
    for (int s = 0; s < SETTLE; s++) begin
      m_edge(ok); if (!ok) return;
      if (!start || !zone_enable[m_zone]) begin ab = 1; m_push(0, 1, 1, 0); break; end
      m_push(s == SETTLE - 1, 1, 1, 0);
    end
    if (!ab) begin
      n = 0;
      forever begin
        m_edge(ok); if (!ok) return;
        if (!start || !zone_enable[m_zone]) begin m_push(0, 1, 1, 0); break; end
        if (n == MAX_ON - 1) begin m_push(0, 1, 1, 1); break; end
        if (m_moist(m_zone) >= WET && n >= MIN_ON - 1) begin m_push(0, 1, 1, 0); break; end
        m_push(1, 1, 1, 0);
        n++;
      end
    end
    m_edge(ok); if (!ok) return;
    m_push(0, 0, 1, 0);
    for (int c = 0; c < COOL; c++) begin
      m_edge(ok); if (!ok) return;
      m_push(0, 0, c != COOL - 1, 0);
    end
  endtask

  initial begin : model
    bit ok;
    forever begin
      m_lk = '0; m_ptr = 0; m_zone = 0;
      wait (reset === 1'b1);
      ok = 1;
      while (ok) m_grant(ok);
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    obs_t a, e;
    forever begin
      @(posedge clk); #1;
      a.pump = pump; a.valve = valve; a.az = active_zone; a.busy = busy;
      a.tp = timeout_pulse; a.lk = lockout;
      if (!reset) begin
        exp_q.delete();
        checks++;
        if (a !== '0) begin
          errors++;
          $display("FAIL reset_outputs @%0t: got pump=%0b valve=%b zone=%0d busy=%0b tp=%0b lockout=%b, expected all zero",
                   $time, a.pump, a.valve, a.az, a.busy, a.tp, a.lk);
        end
      end else if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty @%0t: DUT output with no expectation", $time);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs @%0t: got pump=%0b valve=%b zone=%0d busy=%0b tp=%0b lockout=%b, expected pump=%0b valve=%b zone=%0d busy=%0b tp=%0b lockout=%b",
                   $time, a.pump, a.valve, a.az, a.busy, a.tp, a.lk,
                   e.pump, e.valve, e.az, e.busy, e.tp, e.lk);
        end
      end
    end
  end

  // ---------------- event observers ----------------
  int           pump_run = 0, last_pump_len = 0, tp_count = 0;
  int           glog[$];
  logic [N-1:0] prev_valve = '0;

  initial begin : observer
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        pump_run = 0; prev_valve = '0;
      end else begin
        if (pump) pump_run++;
        else if (pump_run != 0) begin last_pump_len = pump_run; pump_run = 0; end
        if (prev_valve == '0 && valve != '0) glog.push_back(int'(active_zone));
        if (timeout_pulse) tp_count++;
        prev_valve = valve;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_moist(input int z, input int v);
    moisture[z*MW +: MW] = 4'(v);
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < N; i++) set_moist(i, v);
  endtask

  function automatic bit cond(input int what);
    case (what)
      0:       return pump === 1'b1;
      1:       return busy === 1'b0;
      default: return valve != '0;
    endcase
  endfunction

  task automatic wait_until(input int what, input string name);
    int n = 0;
    while (!cond(what) && n < 400) begin @(negedge clk); n++; end
    if (!cond(what)) begin
      checks++; errors++;
      $display("FAIL %s: condition not reached within 400 cycles", name);
    end
  endtask

  // Lets each grant water until wet at MIN_ON, then re-dries the zone.
  task automatic serve(input int cnt);
    int z;
    for (int g = 0; g < cnt; g++) begin
      wait_until(0, "serve_pump");
      z = int'(active_zone);
      set_moist(z, 14);
      wait_until(1, "serve_idle");
      if (g == cnt - 1) start = 1'b0;
      set_moist(z, 2);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int gs, tpb;
    int exp_rr[5]  = '{0, 1, 2, 3, 0};
    int exp_dis[4] = '{1, 2, 3, 1};

    set_all(10);
    repeat (3) @(negedge clk);

    // Single dry zone, goes wet early: pump must still run MIN_ON cycles.
    reset = 1'b1; start = 1'b1; set_moist(2, 3);
    wait_until(0, "single_pump");
    check_int("single_grant_zone", int'(active_zone), 2);
    repeat (3) @(negedge clk);
    set_moist(2, 14);
    wait_until(1, "single_idle");
    check_int("single_pump_len", last_pump_len, MIN_ON);
    set_moist(2, 10);
    start = 1'b0;

    // Round-robin from a fresh pointer.
    pulse_reset();
    glog.delete();
    set_all(2); start = 1'b1;
    serve(5);
    check_int("rr_grant_count", glog.size(), 5);
    for (int i = 0; i < 5 && i < glog.size(); i++) check_int("rr_grant_order", glog[i], exp_rr[i]);
    wait_until(1, "rr_idle");

    // Timeout on zone 1, lockout, no regrant, then clear and regrant.
    set_all(10); set_moist(1, 2); start = 1'b1;
    tpb = tp_count;
    wait_until(0, "tmo_pump");
    check_int("tmo_zone", int'(active_zone), 1);
    wait_until(1, "tmo_idle");
    check_int("tmo_pump_len", last_pump_len, MAX_ON);
    check_int("tmo_pulse_count", tp_count - tpb, 1);
    check_int("tmo_lockout", int'(lockout), 2);
    gs = glog.size();
    repeat (20) @(negedge clk);
    check_int("tmo_no_regrant", glog.size(), gs);
    clear_fault = 1'b1; @(negedge clk); clear_fault = 1'b0;
    wait_until(0, "clr_regrant_pump");
    check_int("clr_regrant_zone", glog[$], 1);
    // clear_fault on the very edge of the second timeout
    repeat (MAX_ON - 1) @(negedge clk);
    clear_fault = 1'b1; @(negedge clk); clear_fault = 1'b0;
    check_int("clr_tmo_same_edge_lockout", int'(lockout), 2);
    check_int("clr_tmo_pump_len", last_pump_len, MAX_ON);
    set_moist(1, 10);
    wait_until(1, "clr_tmo_idle");

    // Abort by dropping start in WATER cycle 3.
    set_moist(3, 2); start = 1'b1;
    wait_until(0, "abort_pump");
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_until(1, "abort_idle");
    check_int("abort_pump_len", last_pump_len, 4);
    gs = glog.size();
    repeat (20) @(negedge clk);
    check_int("abort_no_grant", glog.size(), gs);

    // Async reset in the middle of WATER.
    set_all(2); start = 1'b1;
    wait_until(0, "rst_pump");
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_int("rst_pump_now", int'(pump), 0);
    check_int("rst_valve_now", int'(valve), 0);
    check_int("rst_lockout_now", int'(lockout), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_until(2, "rst_regrant");
    check_int("rst_priority_zone0", glog[$], 0);
    start = 1'b0;
    wait_until(1, "rst_idle");

    // Zone 0 disabled, everyone dry.
    zone_enable = 4'b1110; start = 1'b1;
    gs = glog.size();
    serve(4);
    check_int("dis_grant_count", glog.size() - gs, 4);
    for (int i = 0; i < 4 && gs + i < glog.size(); i++) check_int("dis_grant_order", glog[gs + i], exp_dis[i]);
    wait_until(1, "dis_idle");
    zone_enable = '1;

    // Random traffic against the model.
    start = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      clear_fault = 1'b0;
      if ($urandom_range(0, 7) == 0) set_moist(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 63) == 0) start = ~start;
      if ($urandom_range(0, 99) == 0) zone_enable = N'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) clear_fault = 1'b1;
    end
    @(negedge clk);
    clear_fault = 1'b0; start = 1'b0;
    repeat (60) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
